// File: rtl/circuito_exp5_pkg.sv
// Shared definitions for the circuito_exp5 sequence-memory game:
// datapath widths, FSM state codes and the fixed play sequence.
package circuito_exp5_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int ROM_DEPTH = 1 << ADDR_W;

  // Highest round index; completing it wins the game.
  localparam logic [ADDR_W-1:0] ULTIMA_RODADA = '1;

  // State codes are what db_estado shows on the debug display.
  typedef enum logic [3:0] {
    ST_INICIAL        = 4'h0,
    ST_PREPARACAO     = 4'h1,
    ST_ESPERA_JOGADA  = 4'h2,
    ST_REGISTRA       = 4'h4,
    ST_COMPARA        = 4'h5,
    ST_PROXIMA_JOGADA = 4'h6,
    ST_PROXIMA_RODADA = 4'h7,
    ST_FIM_ACERTOU    = 4'hA,
    ST_FIM_TIMEOUT    = 4'hD,
    ST_FIM_ERROU      = 4'hE
  } estado_t;

  // One-hot sequence the player must reproduce, one button per entry.
  localparam logic [DATA_W-1:0] SEQUENCIA [ROM_DEPTH] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b0001, 4'b0100
  };

endpackage

// File: rtl/circuito_exp5_if.sv
// Player-facing signals of the game: start level, buttons and results.
interface circuito_exp5_if;
  import circuito_exp5_pkg::*;

  logic              iniciar;
  logic [DATA_W-1:0] botoes;
  logic              acertou;
  logic              errou;
  logic              pronto;
  logic [DATA_W-1:0] leds;

  // The player / board side drives start and buttons.
  modport master (
    output iniciar, botoes,
    input  acertou, errou, pronto, leds
  );

  // The game core consumes the inputs and reports the outcome.
  modport slave (
    input  iniciar, botoes,
    output acertou, errou, pronto, leds
  );

endinterface

// File: rtl/circuito_exp5_hexa7seg.sv
// 4-bit hexadecimal to seven-segment decoder.
// Output is active-low with bit order {g,f,e,d,c,b,a}.
module hexa7seg (
  input  logic [3:0] i_hexa,
  output logic [6:0] o_seg
);

  // Pure lookup of the glyph for each hex digit.
  always_comb begin
    // NOTE: assigning a default before the case keeps this block a pure
    // mux; any path that left o_seg unassigned would infer a latch.
    o_seg = 7'b111_1111;
    case (i_hexa)
      4'h0: o_seg = 7'b100_0000;
      4'h1: o_seg = 7'b111_1001;
      4'h2: o_seg = 7'b010_0100;
      4'h3: o_seg = 7'b011_0000;
      4'h4: o_seg = 7'b001_1001;
      4'h5: o_seg = 7'b001_0010;
      4'h6: o_seg = 7'b000_0010;
      4'h7: o_seg = 7'b111_1000;
      4'h8: o_seg = 7'b000_0000;
      4'h9: o_seg = 7'b001_0000;
      4'hA: o_seg = 7'b000_1000;
      4'hB: o_seg = 7'b000_0011;
      4'hC: o_seg = 7'b100_0110;
      4'hD: o_seg = 7'b010_0001;
      4'hE: o_seg = 7'b000_0110;
      4'hF: o_seg = 7'b000_1110;
      default: o_seg = 7'b111_1111;
    endcase
  end

endmodule

// File: rtl/circuito_exp5.sv
// circuito_exp5: "Genius"-style sequence memory game.
// In round N the player re-enters ROM entries 0..N; a wrong press ends the
// game, finishing round 15 wins it. Build option CIRCUITO_EXP5_TIMEOUT_EN
// adds a per-play timer that ends the game after TIMEOUT_CYCLES idle clocks.
module circuito_exp5
  import circuito_exp5_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 3000
) (
  input  logic                 clock,
  input  logic                 reset,
  circuito_exp5_if.slave       bus,
  output logic                 db_igual,
  output logic [6:0]           db_contagem,
  output logic [6:0]           db_memoria,
  output logic [6:0]           db_estado,
  output logic [6:0]           db_jogadafeita,
  output logic [6:0]           db_limite,
  output logic                 db_clock,
  output logic                 db_iniciar,
  output logic                 db_tem_jogada,
  output logic                 db_timeout
);

  estado_t           r_estado;
  estado_t           w_estado_next;
  logic [ADDR_W-1:0] r_endereco;
  logic [ADDR_W-1:0] r_limite;
  logic [DATA_W-1:0] r_jogada;
  logic [DATA_W-1:0] w_memoria;
  logic              r_tem_jogada_q;
  logic              w_tem_jogada;
  logic              w_jogada_feita;
  logic              w_igual;
  logic              w_timeout;
  logic              w_acertou;
  logic              w_errou;
  logic              w_pronto;
  logic              w_db_timeout;

  // The sequence is a constant table, so it has no storage to reset.
  assign w_memoria      = SEQUENCIA[r_endereco];
  assign w_tem_jogada   = |bus.botoes;
  assign w_jogada_feita = w_tem_jogada & ~r_tem_jogada_q;
  assign w_igual        = (r_jogada == w_memoria);

  // Delay of the button activity, so a held button yields one play pulse.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) r_tem_jogada_q <= 1'b0;
    else       r_tem_jogada_q <= w_tem_jogada;
  end

  // Play address and round limit counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_endereco <= '0;
      r_limite   <= '0;
    end else begin
      case (r_estado)
        ST_PREPARACAO: begin
          r_endereco <= '0;
          r_limite   <= '0;
        end
        ST_PROXIMA_JOGADA: r_endereco <= r_endereco + 1'b1;
        ST_PROXIMA_RODADA: begin
          r_endereco <= '0;
          r_limite   <= r_limite + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Play register: captures the pressed button, cleared at game start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          r_jogada <= '0;
    else if (r_estado == ST_PREPARACAO) r_jogada <= '0;
    else if (r_estado == ST_REGISTRA)   r_jogada <= bus.botoes;
  end

`ifdef CIRCUITO_EXP5_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] r_timer;

  // Idle timer: runs only while waiting for a play, restarts per play.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (r_estado == ST_PREPARACAO || r_estado == ST_REGISTRA) begin
      r_timer <= '0;
    end else if (r_estado == ST_ESPERA_JOGADA) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_timeout = (r_estado == ST_ESPERA_JOGADA) && (r_timer == TIMER_LAST);
`else
  // No timer: the game waits for a play indefinitely.
  assign w_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= ST_INICIAL;
    else       r_estado <= w_estado_next;
  end

  // FSM next state and Moore outputs.
  always_comb begin
    w_estado_next = r_estado;
    w_acertou     = 1'b0;
    w_errou       = 1'b0;
    w_pronto      = 1'b0;
    w_db_timeout  = 1'b0;
    case (r_estado)
      ST_INICIAL:        if (bus.iniciar) w_estado_next = ST_PREPARACAO;
      ST_PREPARACAO:     w_estado_next = ST_ESPERA_JOGADA;
      ST_ESPERA_JOGADA: begin
        // A play in the same cycle as the timeout still counts.
        if (w_jogada_feita) w_estado_next = ST_REGISTRA;
        else if (w_timeout) w_estado_next = ST_FIM_TIMEOUT;
      end
      ST_REGISTRA:       w_estado_next = ST_COMPARA;
      ST_COMPARA: begin
        if (!w_igual)                    w_estado_next = ST_FIM_ERROU;
        else if (r_endereco < r_limite)  w_estado_next = ST_PROXIMA_JOGADA;
        else if (r_limite == ULTIMA_RODADA) w_estado_next = ST_FIM_ACERTOU;
        else                             w_estado_next = ST_PROXIMA_RODADA;
      end
      ST_PROXIMA_JOGADA: w_estado_next = ST_ESPERA_JOGADA;
      ST_PROXIMA_RODADA: w_estado_next = ST_ESPERA_JOGADA;
      ST_FIM_ACERTOU: begin
        w_pronto  = 1'b1;
        w_acertou = 1'b1;
        if (bus.iniciar) w_estado_next = ST_PREPARACAO;
      end
      ST_FIM_ERROU: begin
        w_pronto = 1'b1;
        w_errou  = 1'b1;
        if (bus.iniciar) w_estado_next = ST_PREPARACAO;
      end
      ST_FIM_TIMEOUT: begin
        w_pronto     = 1'b1;
        w_errou      = 1'b1;
        w_db_timeout = 1'b1;
        if (bus.iniciar) w_estado_next = ST_PREPARACAO;
      end
      default:           w_estado_next = ST_INICIAL;
    endcase
  end

  assign bus.acertou = w_acertou;
  assign bus.errou   = w_errou;
  assign bus.pronto  = w_pronto;
  assign bus.leds    = r_jogada;

  assign db_igual      = w_igual;
  assign db_clock      = clock;
  assign db_iniciar    = bus.iniciar;
  assign db_tem_jogada = w_tem_jogada;
  assign db_timeout    = w_db_timeout;

  hexa7seg u_seg_contagem (.i_hexa(r_endereco), .o_seg(db_contagem));
  hexa7seg u_seg_memoria  (.i_hexa(w_memoria),  .o_seg(db_memoria));
  hexa7seg u_seg_estado   (.i_hexa(r_estado),   .o_seg(db_estado));
  hexa7seg u_seg_jogada   (.i_hexa(r_jogada),   .o_seg(db_jogadafeita));
  hexa7seg u_seg_limite   (.i_hexa(r_limite),   .o_seg(db_limite));

endmodule

// File: tb/tb_circuito_exp5.sv
// Self-checking bench for circuito_exp5 (sequence memory game).
module tb_circuito_exp5;

  localparam int TIMEOUT = 3000;

  typedef struct {
    logic [3:0] leds;
    logic       igual;
  } exp_t;

  // Reference sequence of the game, written out independently.
  localparam logic [3:0] SEQ [16] = '{
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0100, 4'b0010, 4'b0001, 4'b0001,
    4'b0010, 4'b0010, 4'b0100, 4'b0100,
    4'b1000, 4'b1000, 4'b0001, 4'b0100
  };

  logic       clock = 1'b0;
  logic       reset;
  logic       db_igual;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita, db_limite;
  logic       db_clock, db_iniciar, db_tem_jogada, db_timeout;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  circuito_exp5_if bus ();

  circuito_exp5 #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus.slave),
    .db_igual       (db_igual),
    .db_contagem    (db_contagem),
    .db_memoria     (db_memoria),
    .db_estado      (db_estado),
    .db_jogadafeita (db_jogadafeita),
    .db_limite      (db_limite),
    .db_clock       (db_clock),
    .db_iniciar     (db_iniciar),
    .db_tem_jogada  (db_tem_jogada),
    .db_timeout     (db_timeout)
  );

  always #5 clock = ~clock;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits.
  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press a button; the expected register/compare result goes to the
  // scoreboard and is checked when the DUT shows the compare state.
  task automatic press(input logic [3:0] btn, input logic exp_igual,
                       input int hold, input int gap);
    exp_t e;
    exp_t got;
    bit   seen = 1'b0;
    e.leds  = btn;
    e.igual = exp_igual;
    sb.push_back(e);
    bus.botoes = btn;
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      if (!seen && db_estado === seg(4'h5)) begin
        seen = 1'b1;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          got = sb.pop_front();
          check("press_leds", 32'(bus.leds), 32'(got.leds));
          check("press_igual", 32'(db_igual), 32'(got.igual));
        end
      end
    end
    check("press_reached_compare", 32'(seen), 32'd1);
    if (!seen && sb.size() != 0) void'(sb.pop_front());
    bus.botoes = 4'b0000;
    cyc(gap);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    reset       = 1'b1;
    bus.iniciar = 1'b0;
    bus.botoes  = 4'b0000;
    cyc(3);
    reset = 1'b0;
    cyc(20);
    check("idle_estado", 32'(db_estado), 32'(seg(4'h0)));
    check("idle_pronto", 32'(bus.pronto), 32'd0);
    check("idle_acertou", 32'(bus.acertou), 32'd0);
    check("idle_errou", 32'(bus.errou), 32'd0);
    check("idle_leds", 32'(bus.leds), 32'd0);
    check("idle_timeout", 32'(db_timeout), 32'd0);
    check("idle_memoria", 32'(db_memoria), 32'(seg(SEQ[0])));

    // Start, holding iniciar across preparacao.
    bus.iniciar = 1'b1;
    cyc(5);
    check("iniciar_copy", 32'(db_iniciar), 32'd1);
    bus.iniciar = 1'b0;
    check("start_estado", 32'(db_estado), 32'(seg(4'h2)));

    // Round 0.
    press(4'b0001, 1'b1, 10, 10);
    check("r0_limite", 32'(db_limite), 32'(seg(4'h1)));
    check("r0_contagem", 32'(db_contagem), 32'(seg(4'h0)));
    check("r0_estado", 32'(db_estado), 32'(seg(4'h2)));
    check("r0_errou", 32'(bus.errou), 32'd0);

    // Rounds 1 and 2.
    press(4'b0001, 1'b1, 10, 10);
    press(4'b0010, 1'b1, 10, 10);
    for (int a = 0; a < 3; a++) press(SEQ[a], 1'b1, 10, 10);
    check("r2_limite", 32'(db_limite), 32'(seg(4'h3)));
    check("r2_errou", 32'(bus.errou), 32'd0);

    // Round 3 with a wrong third press.
    press(4'b0001, 1'b1, 10, 10);
    press(4'b0010, 1'b1, 10, 10);
    press(4'b0010, 1'b0, 10, 10);
    check("err_estado", 32'(db_estado), 32'(seg(4'hE)));
    check("err_pronto", 32'(bus.pronto), 32'd1);
    check("err_errou", 32'(bus.errou), 32'd1);
    check("err_acertou", 32'(bus.acertou), 32'd0);
    check("err_leds", 32'(bus.leds), 32'b0010);
    check("err_jogada7seg", 32'(db_jogadafeita), 32'(seg(4'b0010)));

    // Restart from fim_errou.
    bus.iniciar = 1'b1;
    cyc(1);
    check("restart_prep", 32'(db_estado), 32'(seg(4'h1)));
    bus.iniciar = 1'b0;
    cyc(1);
    check("restart_espera", 32'(db_estado), 32'(seg(4'h2)));
    check("restart_limite", 32'(db_limite), 32'(seg(4'h0)));
    check("restart_contagem", 32'(db_contagem), 32'(seg(4'h0)));
    check("restart_pronto", 32'(bus.pronto), 32'd0);
    check("restart_errou", 32'(bus.errou), 32'd0);
    check("restart_leds", 32'(bus.leds), 32'd0);

    // A long hold must register exactly one play.
    press(4'b0001, 1'b1, 30, 5);
    check("hold_contagem", 32'(db_contagem), 32'(seg(4'h0)));
    check("hold_limite", 32'(db_limite), 32'(seg(4'h1)));
    check("hold_estado", 32'(db_estado), 32'(seg(4'h2)));

    // Asynchronous reset mid-game, with iniciar held.
    reset       = 1'b1;
    bus.iniciar = 1'b1;
    #1;
    check("async_reset_estado", 32'(db_estado), 32'(seg(4'h0)));
    cyc(5);
    check("reset_held_estado", 32'(db_estado), 32'(seg(4'h0)));
    check("reset_leds", 32'(bus.leds), 32'd0);
    reset       = 1'b0;
    bus.iniciar = 1'b0;
    cyc(2);
    check("post_reset_estado", 32'(db_estado), 32'(seg(4'h0)));
    check("post_reset_limite", 32'(db_limite), 32'(seg(4'h0)));

    // Full correct 16-round game.
    bus.iniciar = 1'b1;
    cyc(1);
    bus.iniciar = 1'b0;
    cyc(1);
    for (int r = 0; r < 16; r++)
      for (int a = 0; a <= r; a++)
        press(SEQ[a], 1'b1, 4, 2);
    check("win_estado", 32'(db_estado), 32'(seg(4'hA)));
    check("win_acertou", 32'(bus.acertou), 32'd1);
    check("win_pronto", 32'(bus.pronto), 32'd1);
    check("win_errou", 32'(bus.errou), 32'd0);
    check("win_limite", 32'(db_limite), 32'(seg(4'hF)));

`ifdef CIRCUITO_EXP5_TIMEOUT_EN
    // No press after start: timeout after TIMEOUT clocks in espera_jogada.
    bus.iniciar = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      bus.iniciar = 1'b0;
      n++;
    end while (!(n > 1 && bus.pronto === 1'b1) && n < TIMEOUT + 50);
    check("timeout_latency", 32'(n), 32'(TIMEOUT + 2));
    check("timeout_estado", 32'(db_estado), 32'(seg(4'hD)));
    check("timeout_flag", 32'(db_timeout), 32'd1);
    check("timeout_errou", 32'(bus.errou), 32'd1);
    check("timeout_acertou", 32'(bus.acertou), 32'd0);
`else
    // Without the timer the game waits indefinitely for a play.
    bus.iniciar = 1'b1;
    cyc(1);
    bus.iniciar = 1'b0;
    n = 0;
    repeat (TIMEOUT + 100) begin
      @(negedge clock);
      if (bus.pronto === 1'b1) n++;
    end
    check("notimer_pronto_count", 32'(n), 32'd0);
    check("notimer_estado", 32'(db_estado), 32'(seg(4'h2)));
    check("notimer_flag", 32'(db_timeout), 32'd0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/circuito_exp5.md
Name: circuito_exp5

Overview:
- Top level of a single-player "Genius"-style sequence memory game.
- A fixed 16-entry ROM holds a one-hot 4-bit sequence. In round N the player must re-enter entries 0..N in order on four buttons.
- The block reports success after round 15, or failure on a wrong play or timeout.
- Seven-segment and raw debug outputs expose the internal datapath for board bring-up.

Parameters:
- TIMEOUT_CYCLES, 3000: clocks allowed in espera_jogada before timeout (3 s at 1 kHz).

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  level; starts or restarts a game from inicial or any fim state.
- botoes  in  4  player buttons, one-hot when pressed.
- acertou  out  1  game won.
- errou  out  1  game lost (wrong play or timeout).
- pronto  out  1  game finished.
- leds  out  4  last registered play.
- db_igual  out  1  comparator result: registered play == ROM data.
- db_contagem  out  7  7-seg of play address counter.
- db_memoria  out  7  7-seg of ROM data at that address.
- db_estado  out  7  7-seg of state code.
- db_jogadafeita  out  7  7-seg of registered play.
- db_limite  out  7  7-seg of round limit.
- db_clock  out  1  copy of clock.
- db_iniciar  out  1  copy of iniciar.
- db_tem_jogada  out  1  OR of botoes.
- db_timeout  out  1  timeout flag.

Behaviour:
- Reset: state inicial; address, limit, play register and timer = 0; acertou, errou, pronto, db_timeout = 0.
- ROM contents, addr 0..15: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0001, 0010, 0010, 0100, 0100, 1000, 1000, 0001, 0100. Read is combinational.
- tem_jogada = |botoes.
- jogada_feita = tem_jogada & ~tem_jogada_q. It is a one-cycle pulse per press, however long the button is held.
- FSM is Moore; codes in hex:
  - inicial (0): iniciar -> preparacao.
  - preparacao (1): clear address, limit, play register, timer and result flags -> espera_jogada.
  - espera_jogada (2): timer counts. jogada_feita -> registra. Timer reaching TIMEOUT_CYCLES-1 -> fim_timeout. jogada_feita wins if both occur in the same cycle.
  - registra (4): load botoes into play register; clear timer -> compara.
  - compara (5): transitions as follows.
    - mismatch -> fim_errou.
    - match and address < limit -> proxima_jogada.
    - match and address == limit and limit == 15 -> fim_acertou.
    - match and address == limit and limit < 15 -> proxima_rodada.
  - proxima_jogada (6): address+1 -> espera_jogada.
  - proxima_rodada (7): limit+1, address = 0 -> espera_jogada.
  - fim_acertou (A): pronto = 1, acertou = 1.
  - fim_errou (E): pronto = 1, errou = 1.
  - fim_timeout (D): pronto = 1, errou = 1, db_timeout = 1.
- In any fim state, outputs are held until iniciar, which goes to preparacao.
- Address and limit are 4-bit and never wrap during play.
- leds = play register.
- 7-seg encoding: active-low, bit order {g,f,e,d,c,b,a}, hex digits 0-F.
- Reset asserted mid-game returns to inicial immediately; iniciar held during reset is ignored.
- Holding iniciar across preparacao has no effect beyond the single start.

Optional Feature:
- CIRCUITO_EXP5_TIMEOUT_EN defined: timer and fim_timeout behave as specified above.
- Macro undefined: no timer is built, db_timeout = 0, and espera_jogada waits indefinitely.

Decomposition:
- Shared package holds:
  - state codes;
  - the ROM contents as a constant array;
  - widths DATA_W = 4 and ADDR_W = 4.
- Natural sub-module: hexa7seg, a 4-bit to 7-seg decoder instantiated five times.
- Datapath (counters, ROM, play register, comparator, edge detector, timer) and the FSM stay in this module.

Test Plan:
- Reset pulse, then idle 20 cycles -> db_estado shows 0; pronto, acertou, errou = 0.
- iniciar high 5 cycles; botoes 0001 held 10 cycles -> limit goes 0 -> 1, address 0, FSM back in espera_jogada, errou = 0.
- Round 1: 0001 then 0010. Round 2: 0001, 0010, 0100, each held 10 cycles with 10-cycle gaps -> limit = 3, no error.
- Round 3 entered as 0001, 0010, 0010 -> on the third press db_igual = 0, then fim_errou: pronto = 1, errou = 1, db_estado shows E, leds = 0010.
- iniciar from fim_errou -> preparacao then espera_jogada; limit and address = 0; flags cleared. Reset 5 cycles -> inicial.
- With macro defined: after iniciar, no press for TIMEOUT_CYCLES -> fim_timeout with db_timeout = 1 and errou = 1. A full 16-round correct game -> acertou = 1, pronto = 1.
